block_mem_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 22 ++
 rtl/block_mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_block_mem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache/memory-controller definitions: block geometry, controller
// state encoding and the request kind.
package cache_pkg;

  localparam int BLOCK_WORDS = 32;
  localparam int OFFSET_BITS = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    ISSUE   = 3'd2,
    WAIT    = 3'd3,
    RD_OUT  = 3'd4,
    DONE    = 3'd5
  } state_e;

  typedef enum logic {
    FILL      = 1'b0,
    WRITEBACK = 1'b1
  } req_kind_e;

endpackage

// File: rtl/block_mem_ctrl.sv
// Block-transfer controller: moves one aligned block between the cache's
// streaming fill/writeback handshakes and a fixed-latency single-word
// main-memory port, one word per ISSUE/WAIT round trip.
module block_mem_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int OFFSET_BITS = cache_pkg::OFFSET_BITS,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ext_addr,
  output logic                  ext_ren,
  output logic                  ext_wen,
  output logic [DATA_WIDTH-1:0] ext_wdata,
  input  logic [DATA_WIDTH-1:0] ext_rdata
);
  import cache_pkg::*;

  localparam int KW = $clog2(BLOCK_WORDS);
  localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [KW-1:0] K_LAST   = KW'(BLOCK_WORDS - 1);
  localparam logic [LW-1:0] LAT_LOAD = LW'(MEM_LATENCY - 1);
  // Clears the byte offset so any address inside the block maps to its base.
  localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
    ~(ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1));

  state_e                state_q, state_d;
  req_kind_e             kind_q, kind_d;
  logic [KW-1:0]         k_q, k_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
  logic [DATA_WIDTH-1:0] ext_wdata_q, ext_wdata_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Word address of word kk in the block; the word counter wraps, so the
  // address can never step outside the aligned block.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(
    input logic [ADDR_WIDTH-1:0] b,
    input logic [KW-1:0]         kk
  );
    return b + ADDR_WIDTH'({kk, 2'b00});
  endfunction

  // State register and datapath registers; reset abandons any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      kind_q      <= FILL;
      k_q         <= '0;
      lat_q       <= '0;
      base_q      <= '0;
      ext_addr_q  <= '0;
      ext_wdata_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      k_q         <= k_d;
      lat_q       <= lat_d;
      base_q      <= base_d;
      ext_addr_q  <= ext_addr_d;
      ext_wdata_q <= ext_wdata_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Next-state logic; ext_addr is loaded on every transition into ISSUE so
  // it is already registered when the strobe fires.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    k_d         = k_q;
    lat_d       = lat_q;
    base_d      = base_q;
    ext_addr_d  = ext_addr_q;
    ext_wdata_d = ext_wdata_q;
    rd_data_d   = rd_data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d = req_addr & BASE_MASK;
          kind_d = req_we ? WRITEBACK : FILL;
          k_d    = '0;
          if (req_we) begin
            state_d = WR_DATA;
          end else begin
            state_d    = ISSUE;
            ext_addr_d = req_addr & BASE_MASK;
          end
        end
      end
      WR_DATA: begin
        if (wr_valid) begin
          ext_wdata_d = wr_data;
          ext_addr_d  = word_addr(base_q, k_q);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        lat_d   = LAT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == '0) begin
          if (kind_q == FILL) begin
            rd_data_d = ext_rdata;
            state_d   = RD_OUT;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = (k_q == K_LAST) ? DONE : WR_DATA;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      RD_OUT: begin
        if (rd_ready) begin
          k_d = k_q + 1'b1;
          if (k_q == K_LAST) begin
            state_d = DONE;
          end else begin
            state_d    = ISSUE;
            ext_addr_d = word_addr(base_q, k_q + 1'b1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WR_DATA);
  assign rd_valid  = (state_q == RD_OUT);
  assign rd_last   = (state_q == RD_OUT) && (k_q == K_LAST);
  assign done      = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign ext_ren   = (state_q == ISSUE) && (kind_q == FILL);
  assign ext_wen   = (state_q == ISSUE) && (kind_q == WRITEBACK);
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_block_mem_ctrl.sv
// Scoreboard bench for block_mem_ctrl: expected strobes, fill beats and done
// cycles are queued when a request is launched and retired by a monitor.
module tb_block_mem_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NW = 32;

  typedef struct {
    int        cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          rd_ready = 1'b1;
  logic          done;
  logic          busy;
  logic [AW-1:0] ext_addr;
  logic          ext_ren;
  logic          ext_wen;
  logic [DW-1:0] ext_wdata;
  logic [DW-1:0] ext_rdata;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;

  ev_t   q_ren[$];
  ev_t   q_wen[$];
  beat_t q_beat[$];
  int    q_done[$];

  logic [DW-1:0] p1 = '0;
  logic [DW-1:0] p2 = '0;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          wr_hs = 1'b0;

  block_mem_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BLOCK_WORDS(NW),
    .OFFSET_BITS(7),
    .MEM_LATENCY(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_ready (rd_ready),
    .done     (done),
    .busy     (busy),
    .ext_addr (ext_addr),
    .ext_ren  (ext_ren),
    .ext_wen  (ext_wen),
    .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-cycle memory: read data is address+1.
  always @(posedge clk) begin
    p1 <= ext_ren ? ext_addr + 32'd1 : 32'd0;
    p2 <= p1;
  end
  assign ext_rdata = p2;

  // Writeback source: wr_data is the index of the next word to hand over.
  always @(negedge clk) wr_hs = wr_valid && wr_ready;
  always @(posedge clk) begin
    #1;
    if (wr_hs) wr_data = wr_data + 32'd1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: retires expected events as the DUT produces them.
  always @(negedge clk) begin
    ev_t   e;
    beat_t b;
    int    dc;
    if (ext_ren && ext_wen) chk("strobe_excl", {31'd0, ext_wen}, 32'd0);
    if (ext_ren) begin
      if (q_ren.size() == 0) chk("ren_unexp", {31'd0, ext_ren}, 32'd0);
      else begin
        e = q_ren.pop_front();
        chk("ren_cyc", cyc - t0, e.cyc);
        chk("ren_addr", ext_addr, e.addr);
      end
    end
    if (ext_wen) begin
      if (q_wen.size() == 0) chk("wen_unexp", {31'd0, ext_wen}, 32'd0);
      else begin
        e = q_wen.pop_front();
        chk("wen_cyc", cyc - t0, e.cyc);
        chk("wen_addr", ext_addr, e.addr);
        chk("wen_data", ext_wdata, e.data);
      end
    end
    if (rd_valid) begin
      if (hold_v) chk("rd_stable", rd_data, hold_d);
      if (rd_ready) begin
        if (q_beat.size() == 0) chk("beat_unexp", {31'd0, rd_valid}, 32'd0);
        else begin
          b = q_beat.pop_front();
          chk("beat_data", rd_data, b.data);
          chk("beat_last", {31'd0, rd_last}, {31'd0, b.last});
        end
      end
      hold_v = !rd_ready;
      hold_d = rd_data;
    end else begin
      hold_v = 1'b0;
    end
    if (done) begin
      if (q_done.size() == 0) chk("done_unexp", {31'd0, done}, 32'd0);
      else begin
        dc = q_done.pop_front();
        chk("done_cyc", cyc - t0, dc);
      end
    end
  end

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_req(input logic we, input logic [31:0] addr);
    chk("req_ready_at_start", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    t0        = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic push_fill(input logic [31:0] addr, input int stall_word, input int stall_len);
    logic [31:0] base;
    ev_t   e;
    beat_t b;
    int    extra;
    base = addr & 32'hFFFF_FF80;
    for (int i = 0; i < NW; i++) begin
      extra  = (stall_word >= 0 && i > stall_word) ? stall_len : 0;
      e.cyc  = 1 + 4 * i + extra;
      e.addr = base + 32'(4 * i);
      e.data = 32'd0;
      q_ren.push_back(e);
      b.data = base + 32'(4 * i) + 32'd1;
      b.last = (i == NW - 1);
      q_beat.push_back(b);
    end
    q_done.push_back(129 + ((stall_word >= 0) ? stall_len : 0));
  endtask

  task automatic push_wb(input logic [31:0] addr, input int upto_cyc, input logic with_done);
    logic [31:0] base;
    ev_t e;
    base = addr & 32'hFFFF_FF80;
    for (int i = 0; i < NW; i++) begin
      e.cyc  = 2 + 4 * i;
      e.addr = base + 32'(4 * i);
      e.data = 32'(i);
      if (e.cyc <= upto_cyc) q_wen.push_back(e);
    end
    if (with_done) q_done.push_back(129);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_ren_left"}, q_ren.size(), 32'd0);
    chk({tag, "_wen_left"}, q_wen.size(), 32'd0);
    chk({tag, "_beat_left"}, q_beat.size(), 32'd0);
    chk({tag, "_done_left"}, q_done.size(), 32'd0);
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ren", {31'd0, ext_ren}, 32'd0);
    chk("rst_wen", {31'd0, ext_wen}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_last", {31'd0, rd_last}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_ext_addr", ext_addr, 32'd0);
    chk("rst_ext_wdata", ext_wdata, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Fill, no stalls
    rd_ready = 1'b1;
    push_fill(32'h0000_10A4, -1, 0);
    start_req(1'b0, 32'h0000_10A4);
    chk("fill_busy", {31'd0, busy}, 32'd1);
    wait_rel(130);
    chk("fill_req_ready_back", {31'd0, req_ready}, 32'd1);
    wait_rel(133);
    check_drained("fill");

    // Writeback, no stalls
    wr_data  = 32'd0;
    wr_valid = 1'b1;
    push_wb(32'h0000_2000, 1000, 1'b1);
    start_req(1'b1, 32'h0000_2000);
    chk("wb_wr_ready", {31'd0, wr_ready}, 32'd1);
    wait_rel(130);
    chk("wb_req_ready_back", {31'd0, req_ready}, 32'd1);
    wait_rel(133);
    check_drained("wb");

    // Backpressure: rd_ready low for 5 cycles on word 3 (first offered at 16)
    push_fill(32'h0000_3010, 3, 5);
    start_req(1'b0, 32'h0000_3010);
    wait_rel(16);
    chk("bp_word3_valid", {31'd0, rd_valid}, 32'd1);
    rd_ready = 1'b0;
    wait_rel(21);
    rd_ready = 1'b1;
    wait_rel(138);
    check_drained("bp");

    // Busy rejection: stray writeback request at cycle 40 of a fill
    push_fill(32'h0000_5000, -1, 0);
    start_req(1'b0, 32'h0000_5000);
    wait_rel(40);
    chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h0000_6000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_rel(130);
    chk("busy_req_ready_back", {31'd0, req_ready}, 32'd1);
    check_drained("busy");
    push_fill(32'h0000_7040, -1, 0);
    start_req(1'b0, 32'h0000_7040);
    wait_rel(133);
    check_drained("after_busy");

    // Reset mid-transfer at cycle 50 of a writeback
    wr_data = 32'd0;
    push_wb(32'h0000_4000, 50, 1'b0);
    start_req(1'b1, 32'h0000_4000);
    wait_rel(50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    wait_rel(70);
    check_drained("midrst");
    wr_valid = 1'b0;

    // Fresh fill after the abandoned writeback
    push_fill(32'h0000_8000, -1, 0);
    start_req(1'b0, 32'h0000_8000);
    wait_rel(133);
    check_drained("fresh");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Overall guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, errors=%0d of %0d checks", errs, checks);
    $fatal(1);
  end

endmodule
